// File: rtl/hazard_ctrl_fwd_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
package hazard_ctrl_fwd_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // One pipeline destination: register address, file tag (1 = FP), write enable.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic                  fp;
    logic                  wren;
  } rd_info_t;

endpackage

// File: rtl/hazard_ctrl_fwd_src_match.sv
// Compares one source operand against one destination. Integer x0 never
// matches; f0 is an ordinary register and does.
module hazard_src_match
  import hazard_ctrl_fwd_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  src_fp,
  input  logic                  src_used,
  input  rd_info_t              rd,
  output logic                  hit
);

  logic int_zero;

  // x0 in the integer file is hard-wired zero and can never be a dependency
  assign int_zero = ~src_fp & (src_addr == '0);
  assign hit = rd.wren & src_used & (rd.addr == src_addr) & (rd.fp == src_fp) & ~int_zero;

endmodule

// File: rtl/hazard_ctrl_fwd.sv
// Hazard controller for the 5-stage RV32F pipeline: EX operand forwarding,
// single-bubble load-use stall, branch flush and multi-cycle FP freeze.
//
//   state   | meaning
//   MC_IDLE | no multi-cycle op in EX, normal hazard evaluation
//   MC_BUSY | multi-cycle op occupying EX, front end and EX frozen
//   MC_DONE | last occupancy cycle, stalls released so the op leaves EX
module hazard_ctrl_fwd
  import hazard_ctrl_fwd_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] ID_rs1_addr,
  input  logic [ADDR_W-1:0] ID_rs2_addr,
  input  logic [ADDR_W-1:0] ID_rs3_addr,
  input  logic [2:0]        ID_rs_fp,
  input  logic [2:0]        ID_rs_used,
  input  logic [ADDR_W-1:0] EX_rs1_addr,
  input  logic [ADDR_W-1:0] EX_rs2_addr,
  input  logic [ADDR_W-1:0] EX_rs3_addr,
  input  logic [2:0]        EX_rs_fp,
  input  logic [2:0]        EX_rs_used,
  input  logic [ADDR_W-1:0] EX_rd_addr,
  input  logic [ADDR_W-1:0] MEM_rd_addr,
  input  logic [ADDR_W-1:0] WB_rd_addr,
  input  logic              EX_rd_fp,
  input  logic              MEM_rd_fp,
  input  logic              WB_rd_fp,
  input  logic              EX_rd_wren,
  input  logic              MEM_rd_wren,
  input  logic              WB_rd_wren,
  input  logic              EX_is_load,
  input  logic              EX_is_mc,
  input  logic              EX_br_sel,
  output logic              stall_IF,
  output logic              stall_ID,
  output logic              stall_EX,
  output logic              flush_ID,
  output logic              flush_EX,
  output logic [5:0]        fwd_sel,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  cnt_ld_stall,
  output logic [CNT_W-1:0]  cnt_br_flush,
  output logic [CNT_W-1:0]  cnt_mc_stall
);

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

  logic [2:0][ADDR_W-1:0] id_src;
  logic [2:0][ADDR_W-1:0] ex_src;
  rd_info_t  ex_rd, mem_rd, wb_rd;
  logic [2:0] mem_hit, wb_hit, ld_hit;
  logic       ld_haz, br_eff, ld_eff, flush_ex_int;
  mc_state_e  state;
  logic [3:0] cnt;

  assign id_src = {ID_rs3_addr, ID_rs2_addr, ID_rs1_addr};
  assign ex_src = {EX_rs3_addr, EX_rs2_addr, EX_rs1_addr};
  assign ex_rd  = '{addr: EX_rd_addr,  fp: EX_rd_fp,  wren: EX_rd_wren};
  assign mem_rd = '{addr: MEM_rd_addr, fp: MEM_rd_fp, wren: MEM_rd_wren};
  assign wb_rd  = '{addr: WB_rd_addr,  fp: WB_rd_fp,  wren: WB_rd_wren};

  for (genvar k = 0; k < 3; k++) begin : g_src
    hazard_src_match u_mem (
      .src_addr(ex_src[k]), .src_fp(EX_rs_fp[k]), .src_used(EX_rs_used[k]),
      .rd(mem_rd), .hit(mem_hit[k])
    );
    hazard_src_match u_wb (
      .src_addr(ex_src[k]), .src_fp(EX_rs_fp[k]), .src_used(EX_rs_used[k]),
      .rd(wb_rd), .hit(wb_hit[k])
    );
    hazard_src_match u_ld (
      .src_addr(id_src[k]), .src_fp(ID_rs_fp[k]), .src_used(ID_rs_used[k]),
      .rd(ex_rd), .hit(ld_hit[k])
    );
    // MEM holds the younger result, so it wins over WB
    assign fwd_sel[2*k +: 2] = mem_hit[k] ? FWD_MEM : (wb_hit[k] ? FWD_WB : FWD_RF);
  end

  // Priority: BUSY freeze > branch flush > load-use. The rst_n term forces
  // stalls/flushes low immediately while reset is held.
  assign ld_haz       = EX_is_load & (|ld_hit);
  assign br_eff       = EX_br_sel & ~mc_busy;
  assign ld_eff       = ld_haz & ~EX_br_sel & ~mc_busy;
  assign flush_ex_int = br_eff | ld_eff;

  assign stall_IF = i_rst_n & (mc_busy | ld_eff);
  assign stall_ID = i_rst_n & (mc_busy | ld_eff);
  assign stall_EX = i_rst_n & mc_busy;
  assign flush_ID = i_rst_n & br_eff;
  assign flush_EX = i_rst_n & flush_ex_int;

  // Multi-cycle occupancy FSM: entry cycle + (MC_LAT-2) BUSY cycles + DONE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= MC_IDLE;
      cnt     <= '0;
      mc_busy <= 1'b0;
    end else begin
      case (state)
        MC_IDLE: begin
          if (EX_is_mc && !flush_ex_int) begin
            cnt <= MC_LOAD;
            if (MC_LAT == 2) begin
              state   <= MC_DONE;
              mc_busy <= 1'b0;
            end else begin
              state   <= MC_BUSY;
              mc_busy <= 1'b1;
            end
          end
        end
        MC_BUSY: begin
          cnt <= cnt - 4'd1;
          // the decrement lands on 1 as we move to DONE
          if (cnt == 4'd2) begin
            state   <= MC_DONE;
            mc_busy <= 1'b0;
          end
        end
        MC_DONE: begin
          state <= MC_IDLE;
        end
        default: begin
          state   <= MC_IDLE;
          mc_busy <= 1'b0;
        end
      endcase
    end
  end

  // Saturating event counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_ld_stall <= '0;
      cnt_br_flush <= '0;
      cnt_mc_stall <= '0;
    end else begin
      if (ld_eff && (cnt_ld_stall != '1)) cnt_ld_stall <= cnt_ld_stall + CNT_W'(1);
      if (br_eff && (cnt_br_flush != '1)) cnt_br_flush <= cnt_br_flush + CNT_W'(1);
      if (mc_busy && (cnt_mc_stall != '1)) cnt_mc_stall <= cnt_mc_stall + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_fwd.sv
// Self-checking bench for hazard_ctrl_fwd: a vector table, hand-written
// multi-cycle sequences, and random stimulus against a behavioural model.
// The DUT uses narrow counters so saturation is reachable quickly.
module tb_hazard_ctrl_fwd;

  localparam int MCL = 4;
  localparam int CW  = 5;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic [2:0][4:0] id_a;
    logic [2:0]      idfp, idu;
    logic [2:0][4:0] ex_a;
    logic [2:0]      exfp, exu;
    logic [4:0]      exd, memd, wbd;
    logic            exdfp, memdfp, wbdfp, exw, memw, wbw, ld, mc, br;
  } stim_t;

  // flags = {stall_IF, stall_ID, flush_ID, flush_EX}
  typedef struct packed {
    stim_t      s;
    logic [3:0] flags;
    logic [5:0] fwd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  stim_t cs = '0;

  logic stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, mc_busy;
  logic [5:0] fwd_sel;
  logic [CW-1:0] cnt_ld_stall, cnt_br_flush, cnt_mc_stall;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  int occ  = 0;     // cycles the mc op still occupies EX after the current one
  int m_ld = 0, m_br = 0, m_mc = 0;
  logic e_sif, e_sex, e_fid, e_fex, e_busy;
  logic [5:0] e_fwd;

  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_ctrl_fwd #(.ADDR_W(5), .MC_LAT(MCL), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .ID_rs1_addr(cs.id_a[0]), .ID_rs2_addr(cs.id_a[1]), .ID_rs3_addr(cs.id_a[2]),
    .ID_rs_fp(cs.idfp), .ID_rs_used(cs.idu),
    .EX_rs1_addr(cs.ex_a[0]), .EX_rs2_addr(cs.ex_a[1]), .EX_rs3_addr(cs.ex_a[2]),
    .EX_rs_fp(cs.exfp), .EX_rs_used(cs.exu),
    .EX_rd_addr(cs.exd), .MEM_rd_addr(cs.memd), .WB_rd_addr(cs.wbd),
    .EX_rd_fp(cs.exdfp), .MEM_rd_fp(cs.memdfp), .WB_rd_fp(cs.wbdfp),
    .EX_rd_wren(cs.exw), .MEM_rd_wren(cs.memw), .WB_rd_wren(cs.wbw),
    .EX_is_load(cs.ld), .EX_is_mc(cs.mc), .EX_br_sel(cs.br),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .fwd_sel(fwd_sel), .mc_busy(mc_busy),
    .cnt_ld_stall(cnt_ld_stall), .cnt_br_flush(cnt_br_flush), .cnt_mc_stall(cnt_mc_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input stim_t s, input logic [3:0] f, input logic [5:0] w);
    vec_t r;
    r.s = s; r.flags = f; r.fwd = w;
    return r;
  endfunction

  // a source depends on a destination when it reads what that destination writes
  function automatic bit dep(input logic [4:0] sa, input logic sfp, input logic su,
                             input logic [4:0] da, input logic dfp, input logic dw);
    if (!(dw && su)) return 0;
    if (sfp != dfp || sa != da) return 0;
    if (!sfp && sa == 5'd0) return 0;
    return 1;
  endfunction

  task automatic model_eval();
    bit busy, reads_load;
    busy = (occ >= 2);
    reads_load = 0;
    for (int k = 0; k < 3; k++)
      if (dep(cs.id_a[k], cs.idfp[k], cs.idu[k], cs.exd, cs.exdfp, cs.exw)) reads_load = 1;
    e_busy = busy;
    e_fid  = !busy && cs.br;
    e_sif  = busy || (!busy && cs.ld && reads_load && !cs.br);
    e_sex  = busy;
    e_fex  = e_fid || (!busy && cs.ld && reads_load && !cs.br);
    for (int k = 0; k < 3; k++) begin
      if (dep(cs.ex_a[k], cs.exfp[k], cs.exu[k], cs.memd, cs.memdfp, cs.memw))
        e_fwd[2*k +: 2] = 2'b01;
      else if (dep(cs.ex_a[k], cs.exfp[k], cs.exu[k], cs.wbd, cs.wbdfp, cs.wbw))
        e_fwd[2*k +: 2] = 2'b10;
      else
        e_fwd[2*k +: 2] = 2'b00;
    end
  endtask

  task automatic model_check(input string tag);
    model_eval();
    chk({tag, ".stall_IF"}, 32'(stall_IF), 32'(e_sif));
    chk({tag, ".stall_ID"}, 32'(stall_ID), 32'(e_sif));
    chk({tag, ".stall_EX"}, 32'(stall_EX), 32'(e_sex));
    chk({tag, ".flush_ID"}, 32'(flush_ID), 32'(e_fid));
    chk({tag, ".flush_EX"}, 32'(flush_EX), 32'(e_fex));
    chk({tag, ".mc_busy"}, 32'(mc_busy), 32'(e_busy));
    chk({tag, ".fwd_sel"}, 32'(fwd_sel), 32'(e_fwd));
    chk({tag, ".cnt_ld"}, 32'(cnt_ld_stall), m_ld);
    chk({tag, ".cnt_br"}, 32'(cnt_br_flush), m_br);
    chk({tag, ".cnt_mc"}, 32'(cnt_mc_stall), m_mc);
  endtask

  // advance one clock and move the model along with it
  task automatic tick();
    bit ld_taken;
    model_eval();
    ld_taken = e_sif && !e_busy;
    @(posedge clk);
    if (e_busy && m_mc < SAT) m_mc++;
    if (e_fid && m_br < SAT) m_br++;
    if (ld_taken && m_ld < SAT) m_ld++;
    if (occ > 0) occ--;
    else if (cs.mc && !e_fex) occ = MCL - 1;
    #1;
  endtask

  // mid-cycle asynchronous reset; whatever stimulus is applied stays applied
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    chk({tag, ".rst_flags"}, 32'({stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, mc_busy}), 32'd0);
    chk({tag, ".rst_cnt"}, 32'({cnt_ld_stall, cnt_br_flush, cnt_mc_stall}), 32'd0);
    occ = 0; m_ld = 0; m_br = 0; m_mc = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic run_vec(input string tag, input stim_t s);
    cs = s;
    @(negedge clk);
    model_check(tag);
    tick();
  endtask

  stim_t s;

  initial begin
    // reset state
    #2;
    chk("reset.flags", 32'({stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, mc_busy}), 32'd0);
    chk("reset.cnt", 32'({cnt_ld_stall, cnt_br_flush, cnt_mc_stall}), 32'd0);
    chk("reset.fwd", 32'(fwd_sel), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // vector table: single cycles, FSM idle
    s = '0; tbl.push_back(mkv(s, 4'b0000, 6'b000000));
    s = '0; s.ex_a[0] = 5; s.exu = 3'b001; s.memd = 5; s.memw = 1;
    tbl.push_back(mkv(s, 4'b0000, 6'b000001));
    s = '0; s.ex_a[0] = 5; s.exu = 3'b001; s.wbd = 5; s.wbw = 1;
    tbl.push_back(mkv(s, 4'b0000, 6'b000010));
    s = '0; s.ex_a[1] = 9; s.exu = 3'b010; s.memd = 9; s.memw = 1; s.wbd = 9; s.wbw = 1;
    tbl.push_back(mkv(s, 4'b0000, 6'b000100));
    s = '0; s.ex_a[2] = 3; s.exfp = 3'b100; s.exu = 3'b100; s.memd = 3; s.memw = 1;
    s.wbd = 3; s.wbw = 1; s.wbdfp = 1;
    tbl.push_back(mkv(s, 4'b0000, 6'b100000));
    s = '0; s.exu = 3'b001; s.memw = 1;
    tbl.push_back(mkv(s, 4'b0000, 6'b000000));
    s = '0; s.exfp = 3'b001; s.exu = 3'b001; s.memdfp = 1; s.memw = 1;
    tbl.push_back(mkv(s, 4'b0000, 6'b000001));
    s = '0; s.ex_a[0] = 5; s.memd = 5; s.memw = 1;
    tbl.push_back(mkv(s, 4'b0000, 6'b000000));
    s = '0; s.ex_a[0] = 6; s.ex_a[1] = 6; s.ex_a[2] = 6; s.exu = 3'b111; s.memd = 6;
    s.wbd = 6; s.wbw = 1;
    tbl.push_back(mkv(s, 4'b0000, 6'b101010));
    s = '0; s.ld = 1; s.exd = 7; s.exw = 1; s.id_a[1] = 7; s.idu = 3'b010;
    tbl.push_back(mkv(s, 4'b1101, 6'b000000));
    s = '0; s.ld = 1; s.exdfp = 1; s.exw = 1; s.idfp = 3'b001; s.idu = 3'b001;
    tbl.push_back(mkv(s, 4'b1101, 6'b000000));
    s = '0; s.ld = 1; s.exw = 1; s.idu = 3'b001;
    tbl.push_back(mkv(s, 4'b0000, 6'b000000));
    s = '0; s.exd = 7; s.exw = 1; s.id_a[0] = 7; s.idu = 3'b001;
    tbl.push_back(mkv(s, 4'b0000, 6'b000000));
    s = '0; s.ld = 1; s.exd = 7; s.id_a[0] = 7; s.idu = 3'b001;
    tbl.push_back(mkv(s, 4'b0000, 6'b000000));
    s = '0; s.ld = 1; s.exd = 4; s.exdfp = 1; s.exw = 1; s.id_a[2] = 4; s.idfp = 3'b100; s.idu = 3'b100;
    tbl.push_back(mkv(s, 4'b1101, 6'b000000));
    s = '0; s.ld = 1; s.exd = 4; s.exdfp = 1; s.exw = 1; s.id_a[2] = 4; s.idu = 3'b100;
    tbl.push_back(mkv(s, 4'b0000, 6'b000000));
    s = '0; s.br = 1;
    tbl.push_back(mkv(s, 4'b0011, 6'b000000));
    s = '0; s.br = 1; s.ld = 1; s.exd = 7; s.exw = 1; s.id_a[0] = 7; s.idu = 3'b001;
    tbl.push_back(mkv(s, 4'b0011, 6'b000000));

    foreach (tbl[i]) begin
      cs = tbl[i].s;
      @(negedge clk);
      chk($sformatf("vec%0d.flags", i), 32'({stall_IF, stall_ID, flush_ID, flush_EX}), 32'(tbl[i].flags));
      chk($sformatf("vec%0d.fwd", i), 32'(fwd_sel), 32'(tbl[i].fwd));
      model_check($sformatf("vec%0d", i));
      tick();
    end

    // load-use: one bubble, then WB forwarding
    do_reset("lu");
    s = '0; s.ld = 1; s.exd = 7; s.exw = 1; s.id_a[0] = 7; s.idu = 3'b001; cs = s;
    @(negedge clk);
    chk("lu.c1.flags", 32'({stall_IF, stall_ID, flush_ID, flush_EX}), 32'b1101);
    tick();
    s = '0; s.memd = 7; s.memw = 1; s.id_a[0] = 7; s.idu = 3'b001; cs = s;
    @(negedge clk);
    chk("lu.c2.flags", 32'({stall_IF, stall_ID, flush_ID, flush_EX}), 32'b0000);
    chk("lu.c2.cnt_ld", 32'(cnt_ld_stall), 32'd1);
    tick();
    s = '0; s.wbd = 7; s.wbw = 1; s.ex_a[0] = 7; s.exu = 3'b001; cs = s;
    @(negedge clk);
    chk("lu.c3.fwd", 32'(fwd_sel), 32'b000010);
    chk("lu.c3.stall", 32'(stall_IF), 32'd0);
    tick();

    // multi-cycle op, MC_LAT=4; branch and load-use ignored while BUSY
    do_reset("mc");
    s = '0; s.mc = 1; cs = s;
    @(negedge clk);
    chk("mc.c0.busy", 32'({mc_busy, stall_EX}), 32'b00);
    tick();
    for (int c = 1; c <= 2; c++) begin
      s = '0; s.mc = 1; s.br = 1; s.ld = 1; s.exd = 3; s.exw = 1; s.id_a[0] = 3; s.idu = 3'b001;
      cs = s;
      @(negedge clk);
      chk($sformatf("mc.c%0d.busy", c), 32'({mc_busy, stall_EX, stall_IF, stall_ID}), 32'b1111);
      chk($sformatf("mc.c%0d.flush", c), 32'({flush_ID, flush_EX}), 32'b00);
      model_check($sformatf("mc.c%0d", c));
      tick();
    end
    s = '0; s.mc = 1; cs = s;
    @(negedge clk);
    chk("mc.c3.done", 32'({mc_busy, stall_EX, stall_IF}), 32'b000);
    tick();
    cs = '0;
    @(negedge clk);
    chk("mc.c4.cnt_mc", 32'(cnt_mc_stall), 32'd2);
    chk("mc.c4.cnt_br", 32'(cnt_br_flush), 32'd0);
    model_check("mc.c4");
    tick();

    // branch overriding load-use
    do_reset("br");
    s = '0; s.br = 1; s.ld = 1; s.exd = 7; s.exw = 1; s.id_a[0] = 7; s.idu = 3'b001; cs = s;
    @(negedge clk);
    chk("br.flags", 32'({stall_IF, stall_ID, flush_ID, flush_EX}), 32'b0011);
    tick();
    cs = '0;
    @(negedge clk);
    chk("br.cnt_br", 32'(cnt_br_flush), 32'd1);
    chk("br.cnt_ld", 32'(cnt_ld_stall), 32'd0);
    tick();

    // reset asserted mid-BUSY with a load-use hazard on the inputs
    do_reset("rb");
    s = '0; s.mc = 1; cs = s;
    tick(); tick();
    chk("rb.in_busy", 32'(mc_busy), 32'd1);
    s = '0; s.mc = 1; s.ld = 1; s.exd = 2; s.exw = 1; s.id_a[1] = 2; s.idu = 3'b010; s.br = 1;
    cs = s;
    do_reset("rb.mid");
    cs = '0;
    @(negedge clk);
    chk("rb.after", 32'({mc_busy, stall_IF, stall_ID, stall_EX, flush_ID, flush_EX}), 32'd0);
    tick();
    run_vec("rb.idle", '0);

    // counter saturation
    do_reset("sat");
    s = '0; s.br = 1; cs = s;
    for (int c = 0; c < SAT + 4; c++) tick();
    @(negedge clk);
    chk("sat.cnt_br", 32'(cnt_br_flush), SAT);
    model_check("sat");
    tick();

    // randomized stimulus against the model, with periodic async resets
    do_reset("rnd.start");
    for (int i = 0; i < 500; i++) begin
      if (i % 60 == 59) do_reset($sformatf("rnd%0d", i));
      s = '0;
      for (int k = 0; k < 3; k++) begin
        s.id_a[k] = 5'($urandom_range(0, 3));
        s.ex_a[k] = 5'($urandom_range(0, 3));
      end
      s.idfp = 3'($urandom); s.idu = 3'($urandom);
      s.exfp = 3'($urandom); s.exu = 3'($urandom);
      s.exd = 5'($urandom_range(0, 3)); s.memd = 5'($urandom_range(0, 3));
      s.wbd = 5'($urandom_range(0, 3));
      s.exdfp = 1'($urandom); s.memdfp = 1'($urandom); s.wbdfp = 1'($urandom);
      s.exw = 1'($urandom); s.memw = 1'($urandom); s.wbw = 1'($urandom);
      s.ld = ($urandom_range(0, 3) == 0);
      s.mc = ($urandom_range(0, 7) == 0);
      s.br = ($urandom_range(0, 7) == 0);
      run_vec($sformatf("rnd%0d", i), s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
